uart_word_deframer: RTL and testbench
=====================================

UART_WORD_DEFRAMER -- requirements
Module: uart_word_deframer

Interface
REQ-001 Parameter SYNC_BYTE, default 8'h3F, frame start marker; its bits [7:6] SHALL be 2'b00.
REQ-002 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 tick  input  1  one-cycle strobe: din holds a newly received UART byte.
REQ-005 din  input  8  received byte; sampled only when tick=1.
REQ-006 dout  output  16  last complete decoded word.
REQ-007 ready  output  1  one-cycle pulse: dout has just been updated.
REQ-008 frame_err  output  1  one-cycle pulse: a malformed frame was detected.

Function
REQ-009 Frame format SHALL be 4 bytes: SYNC_BYTE, {2'b01, w[15:12], 2'b00}, {2'b10, w[11:6]}, {2'b11, w[5:0]}.
REQ-010 FSM states SHALL be WAIT_SYNC, GET_HI, GET_MID, GET_LO; the FSM SHALL advance only on tick=1.
REQ-011 WAIT_SYNC: din==SYNC_BYTE -> GET_HI; any other byte -> stay, no error.
REQ-012 GET_HI: din[7:6]==2'b01 and din[1:0]==2'b00 -> latch din[5:2] into hi nibble, go to GET_MID.
REQ-013 GET_MID: din[7:6]==2'b10 -> latch din[5:0], go to GET_LO.
REQ-014 GET_LO: din[7:6]==2'b11 -> dout <= {hi, mid, din[5:0]}, ready=1 for one cycle, go to WAIT_SYNC.
REQ-015 ready and dout SHALL update on the clock edge that samples the final byte's tick: one cycle of latency.
REQ-016 Tag mismatch in GET_HI/GET_MID/GET_LO: frame_err=1 for one cycle, dout unchanged, no ready.
REQ-017 Tag mismatch where din==SYNC_BYTE: resync, next state GET_HI.
REQ-018 Tag mismatch where din!=SYNC_BYTE: next state WAIT_SYNC.
REQ-019 ready and frame_err SHALL never be high in the same cycle.
REQ-020 Between valid frames, dout SHALL hold its value indefinitely.
REQ-021 tick=0 cycles SHALL leave all state, dout and the latched partial fields unchanged.

Reset
REQ-022 rst=1 SHALL force state WAIT_SYNC, dout=16'h0000, ready=0, frame_err=0, partial fields=0.
REQ-023 Reset mid-frame SHALL discard the partial word; the next frame SHALL need a fresh SYNC_BYTE.
REQ-024 rst SHALL take priority over a coincident tick.

Configuration
REQ-025 With UART_DEFRAMER_ERRCNT_EN defined, an extra output port err_cnt (8 bits) SHALL exist.
REQ-026 err_cnt SHALL reset to 0, increment on each frame_err pulse, and saturate at 8'hFF.
REQ-027 Without UART_DEFRAMER_ERRCNT_EN, err_cnt and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding, the tag constants (2'b00/01/10/11) and the default sync byte value, for reuse by the transmit-side packer.
REQ-029 One sub-module, uart_deframer_tagchk (combinational tag/format check per state), is natural; all sequential logic SHALL remain in uart_word_deframer.

Verification
REQ-030 Bytes 3F,68,AF,CD, each with a tick -> dout=16'hABCD and one ready pulse on the cycle after the CD tick.
REQ-031 Bytes 3F,40,80,C0 -> dout=16'h0000; then bytes 3F,7C,BF,FF -> dout=16'hFFFF, with two ready pulses in total.
REQ-032 Bytes 3F,68,3F,68,AF,CD -> frame_err pulse at the second 3F, then dout=16'hABCD and one ready pulse.
REQ-033 Bytes 3F,69 (bad low bits) -> frame_err pulse, state WAIT_SYNC; following bytes AF,CD -> no ready.
REQ-034 Bytes 3F,68, then rst for one cycle, then AF,CD -> no ready, dout=16'h0000.
REQ-035 din toggling with tick=0 between the bytes of a valid frame -> result identical to REQ-030; with UART_DEFRAMER_ERRCNT_EN, err_cnt=1 after REQ-032.

Source files
------------

// File: rtl/uart_word_deframer_pkg.sv
// rtl/uart_word_deframer_pkg.sv - shared state encoding, byte tags and sync default for the UART word link
package uart_word_deframer_pkg;

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    GET_HI    = 2'd1,
    GET_MID   = 2'd2,
    GET_LO    = 2'd3
  } state_t;

  localparam logic [1:0] TAG_SYNC = 2'b00;
  localparam logic [1:0] TAG_HI   = 2'b01;
  localparam logic [1:0] TAG_MID  = 2'b10;
  localparam logic [1:0] TAG_LO   = 2'b11;

  // Bits [7:6] must stay 2'b00 so the marker can never pass as a data byte.
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'h3F;

  function automatic logic [1:0] byte_tag(input logic [7:0] b);
    return b[7:6];
  endfunction

endpackage

// File: rtl/uart_deframer_tagchk.sv
// rtl/uart_deframer_tagchk.sv - combinational format check of one received byte against the current state
import uart_word_deframer_pkg::*;

module uart_deframer_tagchk #(
  parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
  input  state_t     state,
  input  logic [7:0] din,
  output logic       is_sync,
  output logic       tag_ok
);

  always_comb begin
    is_sync = (din == SYNC_BYTE);
    tag_ok  = 1'b0;
    case (state)
      WAIT_SYNC: tag_ok = is_sync;
      // The high byte carries a 2'b00 pad in its low bits that must also match.
      GET_HI:    tag_ok = (byte_tag(din) == TAG_HI) && (din[1:0] == TAG_SYNC);
      GET_MID:   tag_ok = (byte_tag(din) == TAG_MID);
      GET_LO:    tag_ok = (byte_tag(din) == TAG_LO);
      default:   tag_ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/uart_word_deframer.sv
// rtl/uart_word_deframer.sv - 4-byte UART frame to 16-bit word decoder; UART_DEFRAMER_ERRCNT_EN adds err_cnt
import uart_word_deframer_pkg::*;

module uart_word_deframer #(
  parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic [7:0]  din,
  output logic [15:0] dout,
  output logic        ready,
  output logic        frame_err
`ifdef UART_DEFRAMER_ERRCNT_EN
  ,
  output logic [7:0]  err_cnt
`endif
);

  state_t     state_q;
  state_t     state_d;
  logic [3:0] hi_q;
  logic [5:0] mid_q;
  logic       is_sync;
  logic       tag_ok;
  logic       load_hi;
  logic       load_mid;
  logic       load_word;
  logic       err_d;

  uart_deframer_tagchk #(
    .SYNC_BYTE(SYNC_BYTE)
  ) u_tagchk (
    .state  (state_q),
    .din    (din),
    .is_sync(is_sync),
    .tag_ok (tag_ok)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    load_hi   = 1'b0;
    load_mid  = 1'b0;
    load_word = 1'b0;
    err_d     = 1'b0;
    if (tick) begin
      if (state_q == WAIT_SYNC) begin
        if (is_sync) state_d = GET_HI;
      end else if (!tag_ok) begin
        // A marker arriving mid-frame starts a new frame rather than wasting it.
        err_d   = 1'b1;
        state_d = is_sync ? GET_HI : WAIT_SYNC;
      end else begin
        case (state_q)
          GET_HI: begin
            load_hi = 1'b1;
            state_d = GET_MID;
          end
          GET_MID: begin
            load_mid = 1'b1;
            state_d  = GET_LO;
          end
          GET_LO: begin
            load_word = 1'b1;
            state_d   = WAIT_SYNC;
          end
          default: state_d = WAIT_SYNC;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q      <= 4'h0;
      mid_q     <= 6'h00;
      dout      <= 16'h0000;
      ready     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      ready     <= load_word;
      frame_err <= err_d;
      if (load_hi)   hi_q  <= din[5:2];
      if (load_mid)  mid_q <= din[5:0];
      if (load_word) dout  <= {hi_q, mid_q, din[5:0]};
    end
  end

`ifdef UART_DEFRAMER_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= 8'h00;
    end else if (err_d && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'h01;
    end
  end
`endif

endmodule

// File: tb/tb_uart_word_deframer.sv
// tb/tb_uart_word_deframer.sv - directed scoreboard bench for uart_word_deframer
module tb_uart_word_deframer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic [7:0]  din = 8'h00;
  logic [15:0] dout;
  logic        ready;
  logic        frame_err;
`ifdef UART_DEFRAMER_ERRCNT_EN
  logic [7:0]  err_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int n_ready = 0;
  int n_err = 0;
  int exp_ready_total = 0;
  int exp_err_total = 0;
  int exp_err_since_rst = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_w;

  uart_word_deframer #(
    .SYNC_BYTE(8'h3F)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .din      (din),
    .dout     (dout),
    .ready    (ready),
    .frame_err(frame_err)
`ifdef UART_DEFRAMER_ERRCNT_EN
    ,
    .err_cnt  (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (ready) begin
        n_ready++;
        checks++;
        assert (exp_q.size() !== 0) else begin
          errors++;
          $error("FAIL unexpected_ready: observed dout %h, expected no ready", dout);
        end
        if (exp_q.size() != 0) begin
          exp_w = exp_q.pop_front();
          checks++;
          assert (dout === exp_w) else begin
            errors++;
            $error("FAIL sb_dout: observed %h, expected %h", dout, exp_w);
          end
        end
      end
      if (frame_err) n_err++;
      if (ready || frame_err) begin
        checks++;
        assert ((ready && frame_err) === 1'b0) else begin
          errors++;
          $error("FAIL ready_err_excl: observed both high, expected exclusive");
        end
      end
    end
  end

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      din = 8'($urandom);
      @(negedge clk);
    end
  endtask

  // Drive one byte with a tick, then check the pulses on the following cycle.
  task automatic send(input logic [7:0] b, input logic er, input logic ee);
    din  = b;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    din  = 8'($urandom);
    if (er) exp_ready_total++;
    if (ee) begin
      exp_err_total++;
      exp_err_since_rst++;
    end
    chk16("ready_pulse", {15'd0, ready}, {15'd0, er});
    chk16("err_pulse", {15'd0, frame_err}, {15'd0, ee});
  endtask

  task automatic frame(input logic [15:0] w);
    exp_q.push_back(w);
    send(8'h3F, 1'b0, 1'b0);
    send({2'b01, w[15:12], 2'b00}, 1'b0, 1'b0);
    send({2'b10, w[11:6]}, 1'b0, 1'b0);
    send({2'b11, w[5:0]}, 1'b1, 1'b0);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_err_since_rst = 0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk16("rst_dout", dout, 16'h0000);
    chk16("rst_ready", {15'd0, ready}, 16'd0);
    chk16("rst_err", {15'd0, frame_err}, 16'd0);
    rst = 1'b0;
    exp_err_since_rst = 0;
    idle(2);

    // Basic frame ABCD
    frame(16'hABCD);
    idle(3);
    chk16("hold_abcd", dout, 16'hABCD);

    // All-zeros and all-ones words
    frame(16'h0000);
    chk16("dout_0000", dout, 16'h0000);
    frame(16'hFFFF);
    chk16("dout_ffff", dout, 16'hFFFF);
    idle(2);

    // Sync arriving mid-frame resyncs
    send(8'h3F, 1'b0, 1'b0);
    send(8'h68, 1'b0, 1'b0);
    send(8'h3F, 1'b0, 1'b1);
    exp_q.push_back(16'hABCD);
    send(8'h68, 1'b0, 1'b0);
    send(8'hAF, 1'b0, 1'b0);
    send(8'hCD, 1'b1, 1'b0);
`ifdef UART_DEFRAMER_ERRCNT_EN
    chk16("err_cnt_1", {8'd0, err_cnt}, {8'd0, 8'(exp_err_since_rst)});
`endif
    idle(2);

    // Bad pad bits in high byte drop back to WAIT_SYNC
    frame(16'h1234);
    send(8'h3F, 1'b0, 1'b0);
    send(8'h69, 1'b0, 1'b1);
    send(8'hAF, 1'b0, 1'b0);
    send(8'hCD, 1'b0, 1'b0);
    chk16("bad_hi_hold", dout, 16'h1234);
    idle(2);

    // Reset mid-frame discards partial word
    send(8'h3F, 1'b0, 1'b0);
    send(8'h68, 1'b0, 1'b0);
    pulse_rst();
    chk16("midrst_dout", dout, 16'h0000);
    send(8'hAF, 1'b0, 1'b0);
    send(8'hCD, 1'b0, 1'b0);
    chk16("midrst_after", dout, 16'h0000);

    // Reset wins over a coincident sync tick
    rst = 1'b1; tick = 1'b1; din = 8'h3F;
    @(negedge clk);
    rst = 1'b0; tick = 1'b0;
    exp_err_since_rst = 0;
    send(8'h68, 1'b0, 1'b0);
    send(8'hAF, 1'b0, 1'b0);
    send(8'hCD, 1'b0, 1'b0);
    chk16("rst_prio", dout, 16'h0000);

    // Noise on din between ticks must not disturb the frame
    exp_q.push_back(16'hABCD);
    send(8'h3F, 1'b0, 1'b0); idle(3);
    send(8'h68, 1'b0, 1'b0); idle(5);
    send(8'hAF, 1'b0, 1'b0); idle(2);
    send(8'hCD, 1'b1, 1'b0);
    idle(4);
    chk16("gap_dout", dout, 16'hABCD);

    // Wrong tag in low slot
    frame(16'h5A5A);
    send(8'h3F, 1'b0, 1'b0);
    send(8'h44, 1'b0, 1'b0);
    send(8'h81, 1'b0, 1'b0);
    send(8'h81, 1'b0, 1'b1);
    chk16("bad_lo_hold", dout, 16'h5A5A);
`ifdef UART_DEFRAMER_ERRCNT_EN
    chk16("err_cnt_end", {8'd0, err_cnt}, {8'd0, 8'(exp_err_since_rst)});
`endif
    idle(3);

    chk16("ready_total", 16'(n_ready), 16'(exp_ready_total));
    chk16("err_total", 16'(n_err), 16'(exp_err_total));
    chk16("sb_empty", 16'(exp_q.size()), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
